ob_cn_pool: RTL and testbench

Parametrised conditional-order pool for the order-book engine. It holds up to N pending stop orders issued from the command pipeline. On each trade-execution event it evaluates every held order against the current best bid and best ask. Matured orders are handed, one at a time and round-robin fair, to the downstream maturity consumer. It supersedes the fixed-behaviour conditional table: it adds cancel-by-UID, an overflow reject, an occupancy count and fair maturity arbitration.

---
 rtl/ob_pkg.sv | 47 ++++
 rtl/ob_cn_pool_if.sv | 28 ++
 rtl/ob_cn_pool_entry.sv | 66 ++++++
 rtl/ob_cn_pool.sv | 156 +++++++++++++++
 tb/tb_ob_cn_pool.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ob_pkg.sv
// Order-book shared types: commands, best-price table rows, conditional-entry state.
// Includes the stop-order maturity rule shared by every pool entry.
package ob_pkg;

    localparam int PRICE_W = 16;
    localparam int UID_W   = 8;
    localparam int QTY_W   = 16;

    typedef enum logic [1:0] {
        OP_NOP       = 2'd0,
        OP_BUY_STOP  = 2'd1,
        OP_SELL_STOP = 2'd2,
        OP_CNCL      = 2'd3
    } opcode_t;

    typedef struct packed {
        opcode_t            opcode;
        logic [UID_W-1:0]   uid;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
    } cmd_t;

    typedef struct packed {
        logic [PRICE_W-1:0] price;
    } table_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MATURED = 2'd2
    } cn_state_t;

    // Buy stops trigger when the market ask climbs to the stop price,
    // sell stops when the bid falls to it; an invalid side never triggers.
    function automatic logic cn_matures(input cmd_t cmd, input table_t bid, input logic bid_vld,
                                        input table_t ask, input logic ask_vld);
        logic hit;
        hit = 1'b0;
        case (cmd.opcode)
            OP_BUY_STOP:  hit = ask_vld && (ask.price >= cmd.price);
            OP_SELL_STOP: hit = bid_vld && (bid.price <= cmd.price);
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ob_cn_pool_if.sv
// Command-in / matured-order-out handshake bundle of the conditional-order pool.
// Commands are fire-and-forget; matured orders use valid/accept.
interface ob_cn_pool_if;
    import ob_pkg::*;

    logic cmd_vld_r;
    cmd_t cmd_r;
    logic mtr_accept;
    logic mtr_vld_r;
    cmd_t mtr_r;

    modport slave (
        input  cmd_vld_r,
        input  cmd_r,
        input  mtr_accept,
        output mtr_vld_r,
        output mtr_r
    );

    modport master (
        output cmd_vld_r,
        output cmd_r,
        output mtr_accept,
        input  mtr_vld_r,
        input  mtr_r
    );

endinterface

// File: rtl/ob_cn_pool_entry.sv
// One pool slot: IDLE -> ARMED on alloc, ARMED -> MATURED on a triggering texe, back to IDLE on issue/cancel.
// Latency 1 cycle per transition; cancel overrides both maturity and issue.
module ob_cn_pool_entry
    import ob_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_i,
    input  cmd_t             alloc_cmd_i,
    input  logic             issue_i,
    input  logic             cncl_req_i,
    input  logic [UID_W-1:0] cncl_uid_i,
    input  logic             texe_i,
    input  table_t           bid_i,
    input  logic             bid_vld_i,
    input  table_t           ask_i,
    input  logic             ask_vld_i,
    output logic             cncl_match_o,
    output cn_state_t        state_o,
    output cmd_t             cmd_o
);

    cn_state_t state_q, state_d;
    cmd_t      cmd_q, cmd_d;

    assign cncl_match_o = cncl_req_i && (state_q != IDLE) && (cmd_q.uid == cncl_uid_i);
    assign state_o      = state_q;
    assign cmd_o        = cmd_q;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (alloc_i) begin
                    state_d = ARMED;
                    cmd_d   = alloc_cmd_i;
                end
            end
            ARMED: begin
                if (cncl_match_o) begin
                    state_d = IDLE;
                end else if (texe_i && cn_matures(cmd_q, bid_i, bid_vld_i, ask_i, ask_vld_i)) begin
                    state_d = MATURED;
                end
            end
            MATURED: begin
                if (cncl_match_o || issue_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

endmodule

// File: rtl/ob_cn_pool.sv
// N-entry stop-order pool: lowest-free allocation, cancel-by-uid, round-robin issue of matured orders.
// Matured order visible 2 cycles after texe at the earliest; mtr_r holds while mtr_accept is low.
module ob_cn_pool
    import ob_pkg::*;
#(
    parameter int N     = 4,
    parameter int W_CNT = $clog2(N+1)
) (
    input  logic              clk,
    input  logic              rst,
    ob_cn_pool_if.slave       bus,
    input  logic              cntrl_evt_texe_r,
    input  logic              lm_bid_table_vld_r,
    input  table_t            lm_bid_table_r,
    input  logic              lm_ask_table_vld_r,
    input  table_t            lm_ask_table_r,
    output logic              full_r,
    output logic [W_CNT-1:0]  cnt_r,
    output logic              cncl_vld_r,
    output logic              cncl_hit_r,
    output logic              ovf_r
);

    localparam int PW = $clog2(N);

    cn_state_t        st   [N];
    cmd_t             ecmd [N];
    logic [N-1:0]     idle_v, mat_v, cncl_v, alloc_v, issue_v;

    logic             is_alloc, is_cncl, free_found, ovf_d;
    logic             sel_vld, issue_fire;
    logic [PW-1:0]    sel_idx;
    logic [PW:0]      idx;
    logic [W_CNT-1:0] n_cncl;

    logic             mtr_vld_q, mtr_vld_d;
    cmd_t             mtr_q, mtr_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic             full_q, cncl_vld_q, cncl_hit_q, ovf_q;

    assign is_alloc = bus.cmd_vld_r &&
                      ((bus.cmd_r.opcode == OP_BUY_STOP) || (bus.cmd_r.opcode == OP_SELL_STOP));
    assign is_cncl  = bus.cmd_vld_r && (bus.cmd_r.opcode == OP_CNCL);

    for (genvar g = 0; g < N; g++) begin : g_entry
        ob_cn_pool_entry u_entry (
            .clk          (clk),
            .rst          (rst),
            .alloc_i      (alloc_v[g]),
            .alloc_cmd_i  (bus.cmd_r),
            .issue_i      (issue_v[g]),
            .cncl_req_i   (is_cncl),
            .cncl_uid_i   (bus.cmd_r.uid),
            .texe_i       (cntrl_evt_texe_r),
            .bid_i        (lm_bid_table_r),
            .bid_vld_i    (lm_bid_table_vld_r),
            .ask_i        (lm_ask_table_r),
            .ask_vld_i    (lm_ask_table_vld_r),
            .cncl_match_o (cncl_v[g]),
            .state_o      (st[g]),
            .cmd_o        (ecmd[g])
        );
        assign idle_v[g] = (st[g] == IDLE);
        assign mat_v[g]  = (st[g] == MATURED);
    end

    // Allocation only considers slots idle at the start of the cycle,
    // so a slot freed by issue/cancel this cycle cannot absorb an overflow.
    always_comb begin
        alloc_v    = '0;
        free_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!free_found && idle_v[i]) begin
                alloc_v[i] = is_alloc;
                free_found = 1'b1;
            end
        end
        ovf_d = is_alloc && !free_found;
    end

    // Round-robin search from ptr_q; slots being cancelled are skipped so the
    // issue slot falls through to the next matured order.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!sel_vld && mat_v[idx[PW-1:0]] && !cncl_v[idx[PW-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = idx[PW-1:0];
            end
        end
        issue_fire = sel_vld && (!mtr_vld_q || bus.mtr_accept);
        issue_v    = '0;
        if (issue_fire) begin
            issue_v[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        mtr_vld_d = mtr_vld_q;
        mtr_d     = mtr_q;
        ptr_d     = ptr_q;
        if (issue_fire) begin
            mtr_vld_d = 1'b1;
            mtr_d     = ecmd[sel_idx];
            ptr_d     = (sel_idx == PW'(N-1)) ? '0 : sel_idx + 1'b1;
        end else if (bus.mtr_accept) begin
            mtr_vld_d = 1'b0;
        end
    end

    always_comb begin
        n_cncl = '0;
        for (int i = 0; i < N; i++) begin
            n_cncl = n_cncl + W_CNT'(cncl_v[i]);
        end
        cnt_d = cnt_q + W_CNT'(is_alloc && free_found) - n_cncl - W_CNT'(issue_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtr_vld_q  <= 1'b0;
            mtr_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            cncl_vld_q <= 1'b0;
            cncl_hit_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mtr_vld_q  <= mtr_vld_d;
            mtr_q      <= mtr_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= (cnt_d == W_CNT'(N));
            cncl_vld_q <= is_cncl;
            cncl_hit_q <= |cncl_v;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.mtr_vld_r = mtr_vld_q;
    assign bus.mtr_r     = mtr_q;
    assign cnt_r         = cnt_q;
    assign full_r        = full_q;
    assign cncl_vld_r    = cncl_vld_q;
    assign cncl_hit_r    = cncl_hit_q;
    assign ovf_r         = ovf_q;

endmodule

// File: tb/tb_ob_cn_pool.sv
// Bench for ob_cn_pool: directed vector table, hand-built ordering/cancel sequences, random traffic vs a pool model.
module tb_ob_cn_pool;
    import ob_pkg::*;

    localparam int NE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        texe, bidv, askv;
    table_t      bid, ask;
    logic        full;
    logic [2:0]  cnt;
    logic        cncl_vld, cncl_hit, ovf;
    int          n_vec = 0;
    int          n_err = 0;

    ob_cn_pool_if bus ();

    ob_cn_pool #(.N(NE)) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .cntrl_evt_texe_r   (texe),
        .lm_bid_table_vld_r (bidv),
        .lm_bid_table_r     (bid),
        .lm_ask_table_vld_r (askv),
        .lm_ask_table_r     (ask),
        .full_r             (full),
        .cnt_r              (cnt),
        .cncl_vld_r         (cncl_vld),
        .cncl_hit_r         (cncl_hit),
        .ovf_r              (ovf)
    );

    always #5 clk = ~clk;

    // Pool model: slot state 0=idle 1=armed 2=matured
    int   m_st  [NE];
    cmd_t m_cmd [NE];
    int   m_ptr, m_cnt;
    logic m_mv, m_cv, m_ch, m_ovf;
    cmd_t m_mr;

    typedef struct {
        logic r, cv; opcode_t op; logic [7:0] uid; logic [15:0] pr;
        logic tx, bv; logic [15:0] bp; logic av; logic [15:0] ap; logic acc;
        logic e_mv; logic [7:0] e_uid; logic [2:0] e_cnt; logic e_full, e_cv, e_ch, e_ovf;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(logic r, logic cv, opcode_t op, logic [7:0] uid, logic [15:0] pr,
                                logic tx, logic bv, logic [15:0] bp, logic av, logic [15:0] ap, logic acc,
                                logic e_mv, logic [7:0] e_uid, logic [2:0] e_cnt,
                                logic e_full, logic e_cv, logic e_ch, logic e_ovf);
        vec_t v;
        v.r = r; v.cv = cv; v.op = op; v.uid = uid; v.pr = pr; v.tx = tx; v.bv = bv; v.bp = bp;
        v.av = av; v.ap = ap; v.acc = acc; v.e_mv = e_mv; v.e_uid = e_uid; v.e_cnt = e_cnt;
        v.e_full = e_full; v.e_cv = e_cv; v.e_ch = e_ch; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic cv, input cmd_t c, input logic tx,
                              input logic bv, input logic [15:0] bp, input logic av,
                              input logic [15:0] ap, input logic acc);
        int   ns [NE];
        logic canc [NE];
        int   sel, j;
        if (r) begin
            for (int i = 0; i < NE; i++) begin m_st[i] = 0; m_cmd[i] = '0; end
            m_ptr = 0; m_mv = 0; m_mr = '0; m_cv = 0; m_ch = 0; m_ovf = 0; m_cnt = 0;
            return;
        end
        sel = -1;
        for (int i = 0; i < NE; i++) begin
            canc[i] = cv && c.opcode == OP_CNCL && m_st[i] != 0 && m_cmd[i].uid == c.uid;
            ns[i] = m_st[i];
        end
        if (!m_mv || acc)
            for (int k = 0; k < NE; k++) begin
                j = (m_ptr + k) % NE;
                if (sel < 0 && m_st[j] == 2 && !canc[j]) sel = j;
            end
        for (int i = 0; i < NE; i++) begin
            if (canc[i]) ns[i] = 0;
            else if (m_st[i] == 1 && tx &&
                     ((m_cmd[i].opcode == OP_BUY_STOP  && av && ap >= m_cmd[i].price) ||
                      (m_cmd[i].opcode == OP_SELL_STOP && bv && bp <= m_cmd[i].price)))
                ns[i] = 2;
        end
        if (sel >= 0) begin
            ns[sel] = 0; m_mr = m_cmd[sel]; m_mv = 1; m_ptr = (sel + 1) % NE;
        end else if (acc) m_mv = 0;
        m_ovf = 0;
        if (cv && (c.opcode == OP_BUY_STOP || c.opcode == OP_SELL_STOP)) begin
            j = -1;
            for (int i = 0; i < NE; i++) if (j < 0 && m_st[i] == 0) j = i;
            if (j < 0) m_ovf = 1;
            else begin ns[j] = 1; m_cmd[j] = c; end
        end
        m_cv = cv && c.opcode == OP_CNCL;
        m_ch = 0;
        m_cnt = 0;
        for (int i = 0; i < NE; i++) begin
            if (canc[i]) m_ch = 1;
            m_st[i] = ns[i];
            if (ns[i] != 0) m_cnt++;
        end
    endtask

    task automatic drive(input logic r, input logic cv, input opcode_t op, input logic [7:0] uid,
                         input logic [15:0] pr, input logic tx, input logic bv, input logic [15:0] bp,
                         input logic av, input logic [15:0] ap, input logic acc);
        cmd_t c;
        c.opcode = op; c.uid = uid; c.price = pr; c.qty = 16'(uid) + 16'd3;
        rst = r; bus.cmd_vld_r = cv; bus.cmd_r = c; bus.mtr_accept = acc;
        texe = tx; bidv = bv; bid.price = bp; askv = av; ask.price = ap;
        model_step(r, cv, c, tx, bv, bp, av, ap, acc);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".mtr_vld"}, 64'(bus.mtr_vld_r), 64'(m_mv));
        if (m_mv) chk({tag, ".mtr_r"}, 64'(bus.mtr_r), 64'(m_mr));
        chk({tag, ".cnt"},      64'(cnt),      64'(m_cnt));
        chk({tag, ".full"},     64'(full),     64'(m_cnt == NE));
        chk({tag, ".cncl_vld"}, 64'(cncl_vld), 64'(m_cv));
        chk({tag, ".cncl_hit"}, 64'(cncl_hit), 64'(m_ch));
        chk({tag, ".ovf"},      64'(ovf),      64'(m_ovf));
    endtask

    task automatic nop(input logic acc);
        drive(0, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic alloc(input logic [7:0] uid, input logic [15:0] pr, input logic acc);
        drive(0, 1, OP_BUY_STOP, uid, pr, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        //        r cv op            uid pr  tx bv bp  av ap  acc | mv uid cnt full cv ch ovf
        vt.push_back(mk(1,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   0,0, 0,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP,  1,100,  0,0,0,  0,0,  0,   0,0, 1,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP,  2,200,  0,0,0,  0,0,  0,   0,0, 2,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP,  3,300,  0,0,0,  0,0,  0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP,  4,400,  0,0,0,  0,0,  0,   0,0, 4,1,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP,  5, 10,  0,0,0,  0,0,  0,   0,0, 4,1,0,0,1));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   0,0, 4,1,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  1,0,0,  1,99, 0,   0,0, 4,1,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   0,0, 4,1,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  1,0,0,  1,100,0,   0,0, 4,1,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   1,1, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   1,1, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,1,OP_CNCL,      3,  0,  0,0,0,  0,0,  0,   0,0, 2,0,1,1,0));
        vt.push_back(mk(0,1,OP_CNCL,     99,  0,  0,0,0,  0,0,  0,   0,0, 2,0,1,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   0,0, 2,0,0,0,0));
        vt.push_back(mk(0,1,OP_SELL_STOP, 7, 50,  0,0,0,  0,0,  0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  1,0,50, 0,0,  0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  1,1,50, 0,0,  0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   1,7, 2,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   0,0, 2,0,0,0,0));
        vt.push_back(mk(0,1,OP_CNCL,      2,  0,  1,0,0,  1,250,1,   0,0, 1,0,1,1,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   0,0, 1,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   0,0, 1,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP,  8, 10,  0,0,0,  0,0,  0,   0,0, 2,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP,  9, 10,  0,0,0,  0,0,  0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  1,0,0,  1,500,0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   1,9, 2,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP, 10, 10,  0,0,0,  0,0,  0,   1,9, 3,0,0,0,0));
        vt.push_back(mk(1,0,OP_NOP,       0,  0,  0,0,0,  0,0,  0,   0,0, 0,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP, 11, 20,  0,0,0,  0,0,  0,   0,0, 1,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP, 12, 20,  0,0,0,  0,0,  0,   0,0, 2,0,0,0,0));
        vt.push_back(mk(0,1,OP_BUY_STOP, 13, 20,  0,0,0,  0,0,  0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  1,0,0,  1,20, 0,   0,0, 3,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   1,11,2,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   1,12,1,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   1,13,0,0,0,0,0));
        vt.push_back(mk(0,0,OP_NOP,       0,  0,  0,0,0,  0,0,  1,   0,0, 0,0,0,0,0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].r, vt[i].cv, vt[i].op, vt[i].uid, vt[i].pr, vt[i].tx,
                  vt[i].bv, vt[i].bp, vt[i].av, vt[i].ap, vt[i].acc);
            chk($sformatf("v%0d.mtr_vld", i), 64'(bus.mtr_vld_r), 64'(vt[i].e_mv));
            if (vt[i].e_mv) chk($sformatf("v%0d.uid", i), 64'(bus.mtr_r.uid), 64'(vt[i].e_uid));
            if (vt[i].r)    chk($sformatf("v%0d.mtr_r", i), 64'(bus.mtr_r), 64'd0);
            chk($sformatf("v%0d.cnt", i),      64'(cnt),      64'(vt[i].e_cnt));
            chk($sformatf("v%0d.full", i),     64'(full),     64'(vt[i].e_full));
            chk($sformatf("v%0d.cncl_vld", i), 64'(cncl_vld), 64'(vt[i].e_cv));
            chk($sformatf("v%0d.cncl_hit", i), 64'(cncl_hit), 64'(vt[i].e_ch));
            chk($sformatf("v%0d.ovf", i),      64'(ovf),      64'(vt[i].e_ovf));
        end

        // Back-to-back issue in slot order, then a 5-cycle stall holding mtr_r
        drive(1, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) alloc(8'(30 + k), 10, 0);
        drive(0, 0, OP_NOP, 0, 0, 1, 0, 0, 1, 10, 0);
        for (int k = 0; k < 4; k++) begin
            nop(1);
            cmp_model("b2b");
            chk($sformatf("b2b.uid%0d", k), 64'(bus.mtr_r.uid), 64'(30 + k));
        end
        for (int k = 0; k < 4; k++) alloc(8'(40 + k), 10, 1);
        drive(0, 0, OP_NOP, 0, 0, 1, 0, 0, 1, 10, 0);
        for (int k = 0; k < 6; k++) begin
            nop(0);
            cmp_model("stall");
            chk("stall.uid", 64'(bus.mtr_r.uid), 64'd40);
        end
        for (int k = 1; k < 4; k++) begin
            nop(1);
            chk($sformatf("rel.uid%0d", k), 64'(bus.mtr_r.uid), 64'(40 + k));
        end

        // Cancel of the slot that would have been issued: issue falls to the next one
        drive(1, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        alloc(20, 5, 0);
        alloc(21, 5, 0);
        drive(0, 0, OP_NOP, 0, 0, 1, 0, 0, 1, 5, 0);
        drive(0, 1, OP_CNCL, 20, 0, 0, 0, 0, 0, 0, 0);
        cmp_model("cxi");
        chk("cxi.uid", 64'(bus.mtr_r.uid), 64'd21);
        chk("cxi.hit", 64'(cncl_hit), 64'd1);
        nop(1);
        nop(1);
        cmp_model("cxi.drain");

        // Random traffic against the model
        drive(1, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) < 6,
                  opcode_t'(2'($urandom_range(0, 3))),
                  8'($urandom_range(0, 7)),
                  16'($urandom_range(0, 31)),
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 8,
                  16'($urandom_range(0, 31)),
                  $urandom_range(0, 9) < 8,
                  16'($urandom_range(0, 31)),
                  $urandom_range(0, 9) < 6);
            cmp_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
